// File: rtl/intra_net_requant_mover.sv
// Strided 2-D tile mover: reads 32-bit accumulators, requantises them to int8 and writes them to an activation buffer.
// Build option: define INTRA_NET_REQUANT_ROUND_EN for round-half-up before the shift (default is a truncating shift).
module intra_net_requant_mover #(
  parameter int OUT_DATA_WIDTH = 32,
  parameter int ACT_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int IDX_WIDTH      = 4,
  parameter int DIM_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     cfg_o_base,
  input  logic [ADDR_WIDTH-1:0]     cfg_a_base,
  input  logic [DIM_WIDTH-1:0]      cfg_num_col,
  input  logic [DIM_WIDTH-1:0]      cfg_num_row,
  input  logic [ADDR_WIDTH-1:0]     cfg_o_stride,
  input  logic [ADDR_WIDTH-1:0]     cfg_a_stride,
  input  logic [4:0]                cfg_shift,
  input  logic                      cfg_relu,
  input  logic [IDX_WIDTH-1:0]      cfg_o_idx,
  input  logic [IDX_WIDTH-1:0]      cfg_a_idx,
  input  logic                      rd_hold,
  output logic                      o_rd_en,
  output logic [ADDR_WIDTH-1:0]     o_addr,
  output logic [IDX_WIDTH-1:0]      o_idx,
  input  logic [OUT_DATA_WIDTH-1:0] o_rd_data,
  output logic                      a_w_en,
  output logic [ADDR_WIDTH-1:0]     a_addr,
  output logic [IDX_WIDTH-1:0]      a_idx,
  output logic [ACT_DATA_WIDTH-1:0] a_w_data,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic signed [OUT_DATA_WIDTH:0] LP_MAX =
    $signed((OUT_DATA_WIDTH+1)'((1 << (ACT_DATA_WIDTH-1)) - 1));
  localparam logic signed [OUT_DATA_WIDTH:0] LP_MIN = ~LP_MAX;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0]     r_o_row;
  logic [ADDR_WIDTH-1:0]     r_o_ptr;
  logic [ADDR_WIDTH-1:0]     r_a_row;
  logic [ADDR_WIDTH-1:0]     r_a_ptr;
  logic [ADDR_WIDTH-1:0]     r_o_stride;
  logic [ADDR_WIDTH-1:0]     r_a_stride;
  logic [DIM_WIDTH-1:0]      r_num_col;
  logic [DIM_WIDTH-1:0]      r_num_row;
  logic [DIM_WIDTH-1:0]      r_col;
  logic [DIM_WIDTH-1:0]      r_row;
  logic [4:0]                r_shift;
  logic                      r_relu;
  logic [IDX_WIDTH-1:0]      r_o_idx;
  logic [IDX_WIDTH-1:0]      r_a_idx;
  logic                      r_rd_vld;
  logic [ADDR_WIDTH-1:0]     r_wr_addr;
  logic                      r_a_w_en;
  logic [ADDR_WIDTH-1:0]     r_a_addr;
  logic [ACT_DATA_WIDTH-1:0] r_a_w_data;

  logic                      w_start_ok;
  logic                      w_zero_dim;
  logic                      w_rd_fire;
  logic                      w_last_col;
  logic                      w_last_row;
  logic                      w_last_rd;
  logic signed [OUT_DATA_WIDTH:0] w_x;
  logic signed [OUT_DATA_WIDTH:0] w_y;
  logic [ACT_DATA_WIDTH-1:0] w_q;

  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_zero_dim = (cfg_num_row == '0) || (cfg_num_col == '0);
  assign w_rd_fire  = (r_state == S_RUN) && !rd_hold;
  assign w_last_col = (r_col == r_num_col - DIM_WIDTH'(1));
  assign w_last_row = (r_row == r_num_row - DIM_WIDTH'(1));
  assign w_last_rd  = w_rd_fire && w_last_col && w_last_row;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // DRAIN ends on the final write: nothing left in the read-data stage.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_zero_dim ? S_DONE : S_RUN;
      S_RUN:   if (w_last_rd) w_next = S_DRAIN;
      S_DRAIN: if (r_a_w_en && !r_rd_vld) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_o_row    <= '0;
      r_o_ptr    <= '0;
      r_a_row    <= '0;
      r_a_ptr    <= '0;
      r_o_stride <= '0;
      r_a_stride <= '0;
      r_num_col  <= '0;
      r_num_row  <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_shift    <= '0;
      r_relu     <= 1'b0;
      r_o_idx    <= '0;
      r_a_idx    <= '0;
    end else if (w_start_ok) begin
      r_o_row    <= cfg_o_base;
      r_o_ptr    <= cfg_o_base;
      r_a_row    <= cfg_a_base;
      r_a_ptr    <= cfg_a_base;
      r_o_stride <= cfg_o_stride;
      r_a_stride <= cfg_a_stride;
      r_num_col  <= cfg_num_col;
      r_num_row  <= cfg_num_row;
      r_col      <= '0;
      r_row      <= '0;
      r_shift    <= cfg_shift;
      r_relu     <= cfg_relu;
      r_o_idx    <= cfg_o_idx;
      r_a_idx    <= cfg_a_idx;
    end else if (w_rd_fire) begin
      // Row starts advance by stride from the previous row start, so no multiplier is needed.
      if (w_last_col) begin
        r_col   <= '0;
        r_row   <= r_row + DIM_WIDTH'(1);
        r_o_row <= r_o_row + r_o_stride;
        r_o_ptr <= r_o_row + r_o_stride;
        r_a_row <= r_a_row + r_a_stride;
        r_a_ptr <= r_a_row + r_a_stride;
      end else begin
        r_col   <= r_col + DIM_WIDTH'(1);
        r_o_ptr <= r_o_ptr + ADDR_WIDTH'(1);
        r_a_ptr <= r_a_ptr + ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_x = $signed({o_rd_data[OUT_DATA_WIDTH-1], o_rd_data});
`ifdef INTRA_NET_REQUANT_ROUND_EN
    if (r_shift != 5'd0) begin
      w_x = w_x + $signed((OUT_DATA_WIDTH+1)'(1) << (r_shift - 5'd1));
    end
`endif
    w_y = w_x >>> r_shift;
    if (r_relu && (w_y < 0)) begin
      w_y = '0;
    end
    w_q = w_y[ACT_DATA_WIDTH-1:0];
    if (w_y > LP_MAX) begin
      w_q = LP_MAX[ACT_DATA_WIDTH-1:0];
    end else if (w_y < LP_MIN) begin
      w_q = LP_MIN[ACT_DATA_WIDTH-1:0];
    end
  end

  // Read data arrives one cycle after the strobe; the write is registered one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_vld   <= 1'b0;
      r_wr_addr  <= '0;
      r_a_w_en   <= 1'b0;
      r_a_addr   <= '0;
      r_a_w_data <= '0;
    end else begin
      r_rd_vld  <= w_rd_fire;
      r_wr_addr <= r_a_ptr;
      r_a_w_en  <= r_rd_vld;
      if (r_rd_vld) begin
        r_a_addr   <= r_wr_addr;
        r_a_w_data <= w_q;
      end
    end
  end

  assign o_rd_en  = w_rd_fire;
  assign o_addr   = r_o_ptr;
  assign o_idx    = r_o_idx;
  assign a_w_en   = r_a_w_en;
  assign a_addr   = r_a_addr;
  assign a_idx    = r_a_idx;
  assign a_w_data = r_a_w_data;
  assign busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_intra_net_requant_mover.sv
// Directed bench for intra_net_requant_mover; expected values follow the rounding build when
// INTRA_NET_REQUANT_ROUND_EN is defined.
module tb_intra_net_requant_mover;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] cfg_o_base, cfg_a_base, cfg_o_stride, cfg_a_stride;
  logic [7:0]  cfg_num_col, cfg_num_row;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic [3:0]  cfg_o_idx, cfg_a_idx;
  logic        rd_hold;
  logic        o_rd_en;
  logic [11:0] o_addr;
  logic [3:0]  o_idx;
  logic [31:0] o_rd_data = 32'h0;
  logic        a_w_en;
  logic [11:0] a_addr;
  logic [3:0]  a_idx;
  logic [7:0]  a_w_data;
  logic        busy;
  logic        done;

  int asserts  = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] mem [0:4095];
  logic [11:0] rdAddr [0:511];
  int          rdCyc  [0:511];
  logic [11:0] wrAddr [0:511];
  logic [7:0]  wrData [0:511];
  int rdCnt = 0, wrCnt = 0, doneCnt = 0, busyCnt = 0, lastDoneCyc = 0;
  int rdBase, wrBase, doneBase, busyBase, tStart;

  intra_net_requant_mover dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_o_base(cfg_o_base), .cfg_a_base(cfg_a_base),
    .cfg_num_col(cfg_num_col), .cfg_num_row(cfg_num_row),
    .cfg_o_stride(cfg_o_stride), .cfg_a_stride(cfg_a_stride),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .cfg_o_idx(cfg_o_idx), .cfg_a_idx(cfg_a_idx),
    .rd_hold(rd_hold),
    .o_rd_en(o_rd_en), .o_addr(o_addr), .o_idx(o_idx), .o_rd_data(o_rd_data),
    .a_w_en(a_w_en), .a_addr(a_addr), .a_idx(a_idx), .a_w_data(a_w_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_rd_en) o_rd_data <= mem[o_addr];
  end

  // Transaction log sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (o_rd_en) begin
      rdAddr[rdCnt % 512] = o_addr;
      rdCyc[rdCnt % 512]  = cyc;
      rdCnt++;
    end
    if (a_w_en) begin
      wrAddr[wrCnt % 512] = a_addr;
      wrData[wrCnt % 512] = a_w_data;
      wrCnt++;
    end
    if (done) begin
      doneCnt++;
      lastDoneCyc = cyc;
    end
    if (busy) busyCnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    asserts++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic startOp(input logic [11:0] oBase, input logic [11:0] aBase,
                         input logic [7:0] cols, input logic [7:0] rows,
                         input logic [11:0] oStride, input logic [11:0] aStride,
                         input logic [4:0] shift, input logic relu,
                         input logic [3:0] oIdx, input logic [3:0] aIdx);
    rdBase   = rdCnt;
    wrBase   = wrCnt;
    doneBase = doneCnt;
    busyBase = busyCnt;
    cfg_o_base = oBase;   cfg_a_base = aBase;
    cfg_num_col = cols;   cfg_num_row = rows;
    cfg_o_stride = oStride; cfg_a_stride = aStride;
    cfg_shift = shift;    cfg_relu = relu;
    cfg_o_idx = oIdx;     cfg_a_idx = aIdx;
    start  = 1'b1;
    tStart = cyc;
    tick();
    start = 1'b0;
    cfg_o_base = ~oBase;  cfg_a_base = ~aBase;
    cfg_num_col = 8'd9;   cfg_num_row = 8'd9;
    cfg_o_stride = 12'h7; cfg_a_stride = 12'h5;
    cfg_shift = ~shift;   cfg_relu = ~relu;
    cfg_o_idx = ~oIdx;    cfg_a_idx = ~aIdx;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (doneCnt == doneBase && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, " done seen"}, 32'(doneCnt != doneBase), 32'd1);
    repeat (3) tick();
  endtask

  task automatic applyStimulus(input string tag);
    logic [11:0] rdExp [0:5];
    rdExp = '{12'h010, 12'h011, 12'h012, 12'h014, 12'h015, 12'h016};
    startOp(12'h010, 12'h040, 8'd3, 8'd2, 12'd4, 12'd3, 5'd0, 1'b0, 4'd3, 4'd5);
    waitDone(tag, 40);
    checkOutput({tag, " read count"}, 32'(rdCnt - rdBase), 32'd6);
    checkOutput({tag, " write count"}, 32'(wrCnt - wrBase), 32'd6);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("%s rd%0d addr", tag, i), 32'(rdAddr[(rdBase + i) % 512]), 32'(rdExp[i]));
      checkOutput($sformatf("%s wr%0d addr", tag, i), 32'(wrAddr[(wrBase + i) % 512]), 32'(12'h040 + 12'(i)));
      checkOutput($sformatf("%s wr%0d data", tag, i), 32'(wrData[(wrBase + i) % 512]), 32'(rdExp[i][7:0]));
    end
    checkOutput({tag, " first read cycle"}, 32'(rdCyc[rdBase % 512]), 32'(tStart + 1));
    checkOutput({tag, " done cycle"}, 32'(lastDoneCyc), 32'(tStart + 9));
    checkOutput({tag, " done pulses"}, 32'(doneCnt - doneBase), 32'd1);
    checkOutput({tag, " busy cycles"}, 32'(busyCnt - busyBase), 32'd8);
    checkOutput({tag, " o_idx"}, 32'(o_idx), 32'd3);
    checkOutput({tag, " a_idx"}, 32'(a_idx), 32'd5);
  endtask

  initial begin
    logic [11:0] t5Exp [0:7];
    logic [7:0]  rnd23, rndM6;
    t5Exp = '{12'h020, 12'h021, 12'h022, 12'h023, 12'h028, 12'h029, 12'h02A, 12'h02B};
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
    mem[12'h100] = 32'h0000_1000;
    mem[12'h101] = 32'hFFFF_F000;
    mem[12'h102] = 32'h0000_0350;
    mem[12'h200] = 32'd23;
    mem[12'h201] = 32'hFFFF_FFFA;
    reset = 1'b1; start = 1'b0; rd_hold = 1'b0;
    cfg_o_base = '0; cfg_a_base = '0; cfg_num_col = '0; cfg_num_row = '0;
    cfg_o_stride = '0; cfg_a_stride = '0; cfg_shift = '0; cfg_relu = 1'b0;
    cfg_o_idx = '0; cfg_a_idx = '0;
    repeat (3) tick();

    checkOutput("reset o_rd_en", 32'(o_rd_en), 32'd0);
    checkOutput("reset a_w_en", 32'(a_w_en), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset o_addr", 32'(o_addr), 32'd0);
    checkOutput("reset a_addr", 32'(a_addr), 32'd0);
    checkOutput("reset a_w_data", 32'(a_w_data), 32'd0);
    checkOutput("reset idx", 32'({o_idx, a_idx}), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] basic strided tile");
    applyStimulus("t1");

    $display("[TB] saturation and relu");
    startOp(12'h100, 12'h0A0, 8'd3, 8'd1, 12'd0, 12'd0, 5'd4, 1'b0, 4'd1, 4'd2);
    waitDone("t2a", 40);
    checkOutput("t2a sat high", 32'(wrData[wrBase % 512]), 32'h7F);
    checkOutput("t2a sat low", 32'(wrData[(wrBase + 1) % 512]), 32'h80);
    checkOutput("t2a in range", 32'(wrData[(wrBase + 2) % 512]), 32'h35);
    startOp(12'h100, 12'h0B0, 8'd3, 8'd1, 12'd0, 12'd0, 5'd4, 1'b1, 4'd1, 4'd2);
    waitDone("t2b", 40);
    checkOutput("t2b relu high", 32'(wrData[wrBase % 512]), 32'h7F);
    checkOutput("t2b relu neg", 32'(wrData[(wrBase + 1) % 512]), 32'h00);
    checkOutput("t2b relu addr", 32'(wrAddr[(wrBase + 1) % 512]), 32'h0B1);

    $display("[TB] shift rounding");
`ifdef INTRA_NET_REQUANT_ROUND_EN
    rnd23 = 8'd6;  rndM6 = 8'hFF;
`else
    rnd23 = 8'd5;  rndM6 = 8'hFE;
`endif
    startOp(12'h200, 12'h0C0, 8'd2, 8'd1, 12'd0, 12'd0, 5'd2, 1'b0, 4'd0, 4'd0);
    waitDone("t3", 40);
    checkOutput("t3 data 23", 32'(wrData[wrBase % 512]), 32'(rnd23));
    checkOutput("t3 data -6", 32'(wrData[(wrBase + 1) % 512]), 32'(rndM6));

    $display("[TB] zero dimension");
    startOp(12'h010, 12'h040, 8'd5, 8'd0, 12'd4, 12'd3, 5'd0, 1'b0, 4'd0, 4'd0);
    waitDone("t4", 10);
    repeat (3) tick();
    checkOutput("t4 reads", 32'(rdCnt - rdBase), 32'd0);
    checkOutput("t4 writes", 32'(wrCnt - wrBase), 32'd0);
    checkOutput("t4 done cycle", 32'(lastDoneCyc), 32'(tStart + 1));
    checkOutput("t4 done pulses", 32'(doneCnt - doneBase), 32'd1);
    checkOutput("t4 busy cycles", 32'(busyCnt - busyBase), 32'd0);

    $display("[TB] read hold and ignored start");
    startOp(12'h020, 12'h080, 8'd4, 8'd2, 12'd8, 12'd4, 5'd0, 1'b0, 4'd0, 4'd0);
    tick();
    rd_hold = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rd_hold = 1'b0;
    waitDone("t5", 40);
    repeat (4) tick();
    checkOutput("t5 read count", 32'(rdCnt - rdBase), 32'd8);
    checkOutput("t5 write count", 32'(wrCnt - wrBase), 32'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t5 rd%0d addr", i), 32'(rdAddr[(rdBase + i) % 512]), 32'(t5Exp[i]));
      checkOutput($sformatf("t5 wr%0d addr", i), 32'(wrAddr[(wrBase + i) % 512]), 32'(12'h080 + 12'(i)));
      checkOutput($sformatf("t5 wr%0d data", i), 32'(wrData[(wrBase + i) % 512]), 32'(t5Exp[i][7:0]));
    end
    checkOutput("t5 done cycle", 32'(lastDoneCyc), 32'(tStart + 14));
    checkOutput("t5 done pulses", 32'(doneCnt - doneBase), 32'd1);

    $display("[TB] reset during run");
    startOp(12'h010, 12'h040, 8'd3, 8'd2, 12'd4, 12'd3, 5'd0, 1'b0, 4'd3, 4'd5);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("t6 o_rd_en", 32'(o_rd_en), 32'd0);
    checkOutput("t6 a_w_en", 32'(a_w_en), 32'd0);
    checkOutput("t6 busy", 32'(busy), 32'd0);
    checkOutput("t6 done", 32'(done), 32'd0);
    checkOutput("t6 o_addr", 32'(o_addr), 32'd0);
    checkOutput("t6 a_addr", 32'(a_addr), 32'd0);
    checkOutput("t6 a_w_data", 32'(a_w_data), 32'd0);
    checkOutput("t6 idx", 32'({o_idx, a_idx}), 32'd0);
    reset = 1'b0;
    wrBase = wrCnt;
    repeat (4) tick();
    checkOutput("t6 quiet writes", 32'(wrCnt - wrBase), 32'd0);
    checkOutput("t6 no done", 32'(doneCnt - doneBase), 32'd0);
    applyStimulus("t6 rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
